// File: rtl/alu_pipe_pkg.sv
// Shared constants and decoded-instruction type for the 3-stage ALU pipeline controller.
package alu_pipe_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [3:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [11:0] imm;
    logic        use_imm;
    logic        legal;
  } dec_t;

  localparam dec_t DEC_NOP = '{op: 4'd0, rs1: 5'd0, rs2: 5'd0, rd: 5'd0,
                               imm: 12'd0, use_imm: 1'b0, legal: 1'b0};

endpackage

// File: rtl/alu_pipe_decode.sv
// Combinational RV32I OP/OP-IMM decoder producing the pipeline's decoded-instruction struct.
module alu_pipe_decode
  import alu_pipe_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [6:0] opcode_s;
  logic [2:0] funct3_s;
  logic [6:0] funct7_s;

  assign opcode_s = instr[6:0];
  assign funct3_s = instr[14:12];
  assign funct7_s = instr[31:25];

  // Field extraction and legality check; immediate forms never read rs2.
  always_comb begin
    dec.op      = ALU_ADD;
    dec.rs1     = instr[19:15];
    dec.rs2     = instr[24:20];
    dec.rd      = instr[11:7];
    dec.imm     = instr[31:20];
    dec.use_imm = 1'b0;
    dec.legal   = 1'b0;
    case (opcode_s)
      OPC_OP: begin
        if (funct7_s == F7_BASE) begin
          dec.legal = 1'b1;
          case (funct3_s)
            3'b000:  dec.op = ALU_ADD;
            3'b001:  dec.op = ALU_SLL;
            3'b010:  dec.op = ALU_SLT;
            3'b011:  dec.op = ALU_SLTU;
            3'b100:  dec.op = ALU_XOR;
            3'b101:  dec.op = ALU_SRL;
            3'b110:  dec.op = ALU_OR;
            default: dec.op = ALU_AND;
          endcase
        end else if (funct7_s == F7_ALT) begin
          case (funct3_s)
            3'b000:  begin dec.op = ALU_SUB; dec.legal = 1'b1; end
            3'b101:  begin dec.op = ALU_SRA; dec.legal = 1'b1; end
            default: dec.legal = 1'b0;
          endcase
        end else begin
          dec.legal = 1'b0;
        end
      end
      OPC_OP_IMM: begin
        dec.rs2     = 5'd0;
        dec.use_imm = 1'b1;
        case (funct3_s)
          3'b000: begin dec.op = ALU_ADD;  dec.legal = 1'b1; end
          3'b010: begin dec.op = ALU_SLT;  dec.legal = 1'b1; end
          3'b011: begin dec.op = ALU_SLTU; dec.legal = 1'b1; end
          3'b100: begin dec.op = ALU_XOR;  dec.legal = 1'b1; end
          3'b110: begin dec.op = ALU_OR;   dec.legal = 1'b1; end
          3'b111: begin dec.op = ALU_AND;  dec.legal = 1'b1; end
          3'b001: begin
            dec.op    = ALU_SLL;
            dec.imm   = {7'd0, instr[24:20]};
            dec.legal = (funct7_s == F7_BASE);
          end
          default: begin
            dec.op    = (funct7_s == F7_ALT) ? ALU_SRA : ALU_SRL;
            dec.imm   = {7'd0, instr[24:20]};
            dec.legal = (funct7_s == F7_BASE) || (funct7_s == F7_ALT);
          end
        endcase
      end
      default: dec.legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_pipe_ctrl.sv
// ID/EX/WB issue and hazard controller for the external ALU and register file.
// Define ALU_PIPE_FORWARD_EN to enable EX/WB->ID forwarding; otherwise RAW hazards stall in ID.
module alu_pipe_ctrl
  import alu_pipe_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic [4:0]       rs1_addr,
  output logic [4:0]       rs2_addr,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  output logic [3:0]       alu_op,
  output logic [XLEN-1:0]  alu_a,
  output logic [XLEN-1:0]  alu_b,
  input  logic [XLEN-1:0]  alu_result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             wb_en,
  output logic [4:0]       wb_addr,
  output logic [XLEN-1:0]  wb_data,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  dec_t             dec_s, id_r;
  logic             v_id_r, v_ex_r, v_wb_r;
  logic [3:0]       ex_op_r;
  logic [XLEN-1:0]  ex_a_r, ex_b_r, wb_data_r;
  logic [4:0]       ex_rd_r, wb_rd_r;
  logic             illegal_r;
  logic [CNT_W-1:0] illegal_cnt_r;
  logic             adv_s, hazard_stall_s, accept_s, id_go_s;
  logic [XLEN-1:0]  rs1_val_s, rs2_val_s, imm_ext_s, opb_s;

  alu_pipe_decode u_decode (.instr(in_instr), .dec(dec_s));

  assign adv_s     = !v_wb_r | res_ready;
  assign in_ready  = adv_s & !(v_id_r & hazard_stall_s) & !reset;
  assign accept_s  = in_valid & in_ready;
  assign id_go_s   = v_id_r & id_r.legal & !hazard_stall_s;
  assign rs1_addr  = id_r.rs1;
  assign rs2_addr  = id_r.rs2;
  assign imm_ext_s = {{(XLEN-12){id_r.imm[11]}}, id_r.imm};
  assign opb_s     = id_r.use_imm ? imm_ext_s : rs2_val_s;

`ifdef ALU_PIPE_FORWARD_EN
  // Operand select: youngest in-flight producer wins over the register file.
  always_comb begin
    hazard_stall_s = 1'b0;
    if (id_r.rs1 == 5'd0)                         rs1_val_s = {XLEN{1'b0}};
    else if (v_ex_r && (ex_rd_r == id_r.rs1))     rs1_val_s = alu_result;
    else if (v_wb_r && (wb_rd_r == id_r.rs1))     rs1_val_s = wb_data_r;
    else                                          rs1_val_s = rs1_data;
    if (id_r.rs2 == 5'd0)                         rs2_val_s = {XLEN{1'b0}};
    else if (v_ex_r && (ex_rd_r == id_r.rs2))     rs2_val_s = alu_result;
    else if (v_wb_r && (wb_rd_r == id_r.rs2))     rs2_val_s = wb_data_r;
    else                                          rs2_val_s = rs2_data;
  end
`else
  // RAW scoreboard: hold ID until no valid EX/WB result targets a source register.
  always_comb begin
    hazard_stall_s = v_id_r &
      (((id_r.rs1 != 5'd0) && ((v_ex_r && (ex_rd_r == id_r.rs1)) || (v_wb_r && (wb_rd_r == id_r.rs1)))) ||
       ((id_r.rs2 != 5'd0) && ((v_ex_r && (ex_rd_r == id_r.rs2)) || (v_wb_r && (wb_rd_r == id_r.rs2)))));
    rs1_val_s = (id_r.rs1 == 5'd0) ? {XLEN{1'b0}} : rs1_data;
    rs2_val_s = (id_r.rs2 == 5'd0) ? {XLEN{1'b0}} : rs2_data;
  end
`endif

  // Pipeline stage registers; every stage advances together on adv_s.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_id_r    <= 1'b0;
      id_r      <= DEC_NOP;
      v_ex_r    <= 1'b0;
      ex_op_r   <= 4'd0;
      ex_a_r    <= {XLEN{1'b0}};
      ex_b_r    <= {XLEN{1'b0}};
      ex_rd_r   <= 5'd0;
      v_wb_r    <= 1'b0;
      wb_rd_r   <= 5'd0;
      wb_data_r <= {XLEN{1'b0}};
    end else if (adv_s) begin
      if (accept_s) begin
        v_id_r <= dec_s.legal;
        id_r   <= dec_s;
      end else if (!(v_id_r && hazard_stall_s)) begin
        v_id_r <= 1'b0;
      end
      v_ex_r  <= id_go_s;
      ex_op_r <= id_go_s ? id_r.op   : 4'd0;
      ex_a_r  <= id_go_s ? rs1_val_s : {XLEN{1'b0}};
      ex_b_r  <= id_go_s ? opb_s     : {XLEN{1'b0}};
      ex_rd_r <= id_go_s ? id_r.rd   : 5'd0;
      v_wb_r    <= v_ex_r;
      wb_rd_r   <= v_ex_r ? ex_rd_r    : 5'd0;
      wb_data_r <= v_ex_r ? alu_result : {XLEN{1'b0}};
    end
  end

  // Dropped-instruction pulse and saturating counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal_r     <= 1'b0;
      illegal_cnt_r <= {CNT_W{1'b0}};
    end else begin
      illegal_r <= accept_s & !dec_s.legal;
      if (accept_s && !dec_s.legal && (illegal_cnt_r != {CNT_W{1'b1}}))
        illegal_cnt_r <= illegal_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign alu_op      = ex_op_r;
  assign alu_a       = ex_a_r;
  assign alu_b       = ex_b_r;
  assign res_valid   = v_wb_r;
  assign wb_addr     = wb_rd_r;
  assign wb_data     = wb_data_r;
  assign wb_en       = v_wb_r & res_ready & (wb_rd_r != 5'd0);
  assign illegal     = illegal_r;
  assign illegal_cnt = illegal_cnt_r;

endmodule

// File: tb/tb_alu_pipe_ctrl.sv
// Directed self-checking bench for alu_pipe_ctrl with a behavioural ALU and register file.
module tb_alu_pipe_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = 32'd0;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic [3:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        illegal;
  logic [15:0] illegal_cnt;

  logic [31:0] rf [32];
  logic        rf_init = 1'b0;
  int          cyc = 0;
  int          nrdy_cnt = 0;
  int          ill_seen = 0;
  int          wben_cnt = 0;
  int          acc_q[$];
  int          rc_q[$];
  logic [4:0]  ra_q[$];
  logic [31:0] rd_q[$];
  logic        re_q[$];
  int          tests = 0;
  int          fails = 0;
`ifdef ALU_PIPE_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  alu_pipe_ctrl #(.XLEN(32), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .res_valid(res_valid), .res_ready(res_ready), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .illegal(illegal), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural ALU.
  always_comb begin
    case (alu_op)
      4'd0: alu_result = alu_a + alu_b;
      4'd1: alu_result = alu_a - alu_b;
      4'd2: alu_result = alu_a & alu_b;
      4'd3: alu_result = alu_a | alu_b;
      4'd4: alu_result = alu_a ^ alu_b;
      4'd5: alu_result = alu_a << alu_b[4:0];
      4'd6: alu_result = alu_a >> alu_b[4:0];
      4'd7: alu_result = $signed(alu_a) >>> alu_b[4:0];
      4'd8: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
      4'd9: alu_result = {31'd0, alu_a < alu_b};
      default: alu_result = 32'd0;
    endcase
  end

  assign rs1_data = (rs1_addr == 5'd0) ? 32'd0 : rf[rs1_addr];
  assign rs2_data = (rs2_addr == 5'd0) ? 32'd0 : rf[rs2_addr];

  // Register file: preset x1=10, x2=20, x3=30 on rf_init, else write on wb_en.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rf_init) begin
      for (int i = 0; i < 32; i++)
        rf[i] <= (i == 1) ? 32'd10 : (i == 2) ? 32'd20 : (i == 3) ? 32'd30 : 32'd0;
    end else if (wb_en) begin
      rf[wb_addr] <= wb_data;
    end
  end

  // Monitor sampling between active edges.
  always @(negedge clk) begin
    if (!reset) begin
      if (in_valid && in_ready) acc_q.push_back(cyc);
      if (!in_ready) nrdy_cnt <= nrdy_cnt + 1;
      if (illegal) ill_seen <= ill_seen + 1;
      if (wb_en) wben_cnt <= wben_cnt + 1;
      if (res_valid && res_ready) begin
        rc_q.push_back(cyc);
        ra_q.push_back(wb_addr);
        rd_q.push_back(wb_data);
        re_q.push_back(wb_en);
      end
    end
  end

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] itype(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  task automatic rf_preset();
    rf_init = 1'b1;
    @(posedge clk); #1;
    rf_init = 1'b0;
  endtask

  task automatic send(input logic [31:0] ins);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_instr = ins;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL send_timeout instr=%h in_ready stayed 0", ins);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_res(input int base, input int n, input string name, output bit ok);
    int k;
    k = 0;
    while (rc_q.size() < base + n && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    ok = (rc_q.size() >= base + n);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s_timeout got %0d results, need %0d", name, rc_q.size() - base, n);
    end
  endtask

  task automatic test_reset();
    rf_preset();
    @(negedge clk);
    tests++; if (in_ready !== 1'b0)    begin fails++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    tests++; if (res_valid !== 1'b0)   begin fails++; $display("FAIL rst_res_valid got %b want 0", res_valid); end
    tests++; if (wb_en !== 1'b0)       begin fails++; $display("FAIL rst_wb_en got %b want 0", wb_en); end
    tests++; if (illegal_cnt !== 16'd0) begin fails++; $display("FAIL rst_illegal_cnt got %0d want 0", illegal_cnt); end
    tests++; if ({alu_op, alu_a, alu_b, wb_addr, wb_data} !== 105'd0)
      begin fails++; $display("FAIL rst_datapath got op=%0d a=%h b=%h addr=%0d data=%h want 0", alu_op, alu_a, alu_b, wb_addr, wb_data); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    tests++; if (in_ready !== 1'b1)    begin fails++; $display("FAIL post_rst_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_add();
    int ab, rb; bit ok;
    rf_preset();
    ab = acc_q.size(); rb = rc_q.size();
    send(rtype(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd4));
    wait_res(rb, 1, "add", ok);
    if (ok) begin
      tests++; if (rc_q[rb] - acc_q[ab] != 3) begin fails++; $display("FAIL add_latency got %0d want 3", rc_q[rb] - acc_q[ab]); end
      tests++; if (ra_q[rb] !== 5'd4)   begin fails++; $display("FAIL add_addr got %0d want 4", ra_q[rb]); end
      tests++; if (rd_q[rb] !== 32'd30) begin fails++; $display("FAIL add_data got %0d want 30", rd_q[rb]); end
      tests++; if (re_q[rb] !== 1'b1)   begin fails++; $display("FAIL add_wb_en got %b want 1", re_q[rb]); end
    end
  endtask

  task automatic test_back_to_back();
    int rb, nb, gap_exp, nrdy_exp; bit ok;
    rf_preset();
    rb = rc_q.size(); nb = nrdy_cnt;
    gap_exp  = FWD ? 1 : 3;
    nrdy_exp = FWD ? 0 : 2;
    send(rtype(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd4));
    send(rtype(7'b0100000, 5'd3, 5'd4, 3'b000, 5'd5));
    wait_res(rb, 2, "b2b", ok);
    repeat (3) @(posedge clk);
    #1;
    if (ok) begin
      tests++; if (ra_q[rb] !== 5'd4 || rd_q[rb] !== 32'd30)
        begin fails++; $display("FAIL b2b_x4 got x%0d=%0d want x4=30", ra_q[rb], rd_q[rb]); end
      tests++; if (ra_q[rb+1] !== 5'd5 || rd_q[rb+1] !== 32'd0)
        begin fails++; $display("FAIL b2b_x5 got x%0d=%0d want x5=0", ra_q[rb+1], rd_q[rb+1]); end
      tests++; if (rc_q[rb+1] - rc_q[rb] != gap_exp)
        begin fails++; $display("FAIL b2b_gap got %0d want %0d", rc_q[rb+1] - rc_q[rb], gap_exp); end
    end
    tests++; if (nrdy_cnt - nb != nrdy_exp)
      begin fails++; $display("FAIL b2b_in_ready_low got %0d want %0d", nrdy_cnt - nb, nrdy_exp); end
  endtask

  task automatic test_imm();
    int rb; bit ok;
    logic [4:0]  ea [3];
    logic [31:0] ed [3];
    ea = '{5'd6, 5'd7, 5'd8};
    ed = '{32'd7, 32'd3, 32'd1};
    rf_preset();
    rb = rc_q.size();
    send(itype(12'hFFD, 5'd1, 3'b000, 5'd6));
    send(itype(12'h401, 5'd6, 3'b101, 5'd7));
    send(itype(12'd11, 5'd1, 3'b010, 5'd8));
    wait_res(rb, 3, "imm", ok);
    if (ok) begin
      for (int i = 0; i < 3; i++) begin
        tests++; if (ra_q[rb+i] !== ea[i] || rd_q[rb+i] !== ed[i])
          begin fails++; $display("FAIL imm_%0d got x%0d=%0d want x%0d=%0d", i, ra_q[rb+i], rd_q[rb+i], ea[i], ed[i]); end
      end
    end
  endtask

  task automatic test_backpressure();
    int rb, wb0; bit ok;
    logic [4:0]  ea [3];
    logic [31:0] ed [3];
    ea = '{5'd10, 5'd11, 5'd12};
    ed = '{32'd30, 32'd10, 32'd20};
    rf_preset();
    res_ready = 1'b0;
    send(rtype(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd10));
    send(rtype(7'b0100000, 5'd1, 5'd2, 3'b000, 5'd11));
    send(rtype(7'b0000000, 5'd3, 5'd1, 3'b100, 5'd12));
    wb0 = wben_cnt; rb = rc_q.size();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      tests++; if (res_valid !== 1'b1 || wb_addr !== 5'd10 || wb_data !== 32'd30)
        begin fails++; $display("FAIL bp_hold_%0d got v=%b x%0d=%0d want v=1 x10=30", k, res_valid, wb_addr, wb_data); end
      tests++; if (in_ready !== 1'b0 || wb_en !== 1'b0)
        begin fails++; $display("FAIL bp_block_%0d got in_ready=%b wb_en=%b want 0 0", k, in_ready, wb_en); end
      tests++; if (alu_op !== 4'd1 || alu_a !== 32'd20 || alu_b !== 32'd10)
        begin fails++; $display("FAIL bp_ex_%0d got op=%0d a=%0d b=%0d want 1 20 10", k, alu_op, alu_a, alu_b); end
    end
    tests++; if (wben_cnt != wb0) begin fails++; $display("FAIL bp_no_wb_en got %0d strobes want 0", wben_cnt - wb0); end
    @(posedge clk); #1;
    res_ready = 1'b1;
    wait_res(rb, 3, "bp", ok);
    if (ok) begin
      for (int i = 0; i < 3; i++) begin
        tests++; if (ra_q[rb+i] !== ea[i] || rd_q[rb+i] !== ed[i])
          begin fails++; $display("FAIL bp_ret_%0d got x%0d=%0d want x%0d=%0d", i, ra_q[rb+i], rd_q[rb+i], ea[i], ed[i]); end
      end
      tests++; if (rc_q[rb+2] - rc_q[rb] != 2)
        begin fails++; $display("FAIL bp_rate got span %0d want 2", rc_q[rb+2] - rc_q[rb]); end
    end
  endtask

  task automatic test_illegal();
    int rb, ib;
    rb = rc_q.size(); ib = ill_seen;
    send(32'h00002083);
    send(rtype(7'b0100000, 5'd2, 5'd1, 3'b111, 5'd13));
    repeat (6) @(posedge clk);
    #1;
    tests++; if (ill_seen - ib != 2)    begin fails++; $display("FAIL ill_pulses got %0d want 2", ill_seen - ib); end
    tests++; if (illegal_cnt !== 16'd2) begin fails++; $display("FAIL ill_cnt got %0d want 2", illegal_cnt); end
    tests++; if (rc_q.size() != rb)     begin fails++; $display("FAIL ill_res_valid got %0d results want 0", rc_q.size() - rb); end
  endtask

  task automatic test_reset_midop();
    int rb, wb0; bit ok;
    rf_preset();
    res_ready = 1'b0;
    send(rtype(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd14));
    send(rtype(7'b0000000, 5'd3, 5'd1, 3'b110, 5'd15));
    send(itype(12'd5, 5'd2, 3'b000, 5'd16));
    #2 reset = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b0 || res_valid !== 1'b0 || wb_en !== 1'b0 || illegal !== 1'b0)
      begin fails++; $display("FAIL mid_rst_ctl got rdy=%b v=%b en=%b ill=%b want 0", in_ready, res_valid, wb_en, illegal); end
    tests++; if (illegal_cnt !== 16'd0) begin fails++; $display("FAIL mid_rst_cnt got %0d want 0", illegal_cnt); end
    tests++; if ({alu_op, alu_a, alu_b, wb_addr, wb_data} !== 105'd0)
      begin fails++; $display("FAIL mid_rst_datapath got op=%0d a=%h b=%h addr=%0d data=%h want 0", alu_op, alu_a, alu_b, wb_addr, wb_data); end
    res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    wb0 = wben_cnt; rb = rc_q.size();
    repeat (6) @(posedge clk);
    #1;
    tests++; if (wben_cnt != wb0 || rc_q.size() != rb)
      begin fails++; $display("FAIL mid_rst_flush got %0d strobes %0d results want 0", wben_cnt - wb0, rc_q.size() - rb); end
    send(rtype(7'b0000000, 5'd3, 5'd0, 3'b000, 5'd9));
    wait_res(rb, 1, "post_rst", ok);
    if (ok) begin
      tests++; if (ra_q[rb] !== 5'd9 || rd_q[rb] !== 32'd30 || re_q[rb] !== 1'b1)
        begin fails++; $display("FAIL post_rst_add got x%0d=%0d en=%b want x9=30 en=1", ra_q[rb], rd_q[rb], re_q[rb]); end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_imm();
    test_backpressure();
    test_illegal();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_pipe_ctrl.md
# alu_pipe_ctrl

Issue and hazard controller for the 3-stage pipelined RISC-V ALU. Accepts RV32I OP/OP-IMM instructions over a valid/ready handshake, decodes them to ALU operations, and sequences them through decode (ID), execute (EX) and writeback (WB) stages. It resolves RAW hazards by forwarding, or by stalling when forwarding is compiled out. It drives the external combinational ALU and the register-file read and write ports.

## Interface
- XLEN, 32: datapath width.
- CNT_W, 16: width of the illegal-instruction counter.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  instruction offered.
- in_ready  out  1  instruction accepted when in_valid & in_ready.
- in_instr  in  32  RV32I instruction word.
- rs1_addr, rs2_addr  out  5  register-file read addresses; the read is combinational.
- rs1_data, rs2_data  in  XLEN  register-file read data.
- alu_op  out  4  ALU operation code.
- alu_a, alu_b  out  XLEN  ALU operands.
- alu_result  in  XLEN  combinational ALU result.
- res_valid  out  1  WB stage holds a result.
- res_ready  in  1  consumer accepts the result.
- wb_en  out  1  register write strobe, equal to res_valid & res_ready & (wb_rd != 0).
- wb_addr  out  5  destination register.
- wb_data  out  XLEN  result.
- illegal  out  1  one-cycle pulse when an accepted instruction is dropped.
- illegal_cnt  out  CNT_W  saturating count of dropped instructions.

## Operation
- ALU op codes: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9.
- Decode, OP (0110011):
  - funct7 0000000 selects funct3 ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND.
  - funct7 0100000 is legal only with funct3 000 (SUB) or 101 (SRA).
- Decode, OP-IMM (0010011):
  - alu_b is the sign-extended imm[11:0].
  - Shifts use shamt = instr[24:20]; SLLI requires funct7 0000000; SRLI/SRAI require funct7 0000000 or 0100000.
- Illegal instructions:
  - Any other opcode or funct7 is consumed but never enters ID.
  - illegal pulses in the following cycle and illegal_cnt increments, saturating at all-ones.
- Stage valid bits are v_id, v_ex and v_wb. The pipeline advances when `adv = !v_wb | res_ready`.
- All stages move together on adv. An ID instruction that is stalled by a hazard leaves a bubble in EX.
- in_ready = adv & !(v_id & hazard_stall).
- x0 reads return 0 and are never forwarded or stalled on. rd = x0 results still raise res_valid, but wb_en stays 0.
- Forwarding (FORWARD_EN) for each rs != 0, highest priority first:
  - EX rd match: alu_result.
  - WB rd match: wb_data.
  - Otherwise: the register file.
- Operands are captured into EX on adv, and are recaptured every cycle while the instruction is held in ID.
- alu_op, alu_a and alu_b come from the EX registers. They are held stable while stalled, and are 0 when EX is empty.

## Timing
- Reset values: in_ready=0 during reset and 1 afterwards. All v_* = 0. res_valid, wb_en, illegal and illegal_cnt = 0. alu_op, alu_a, alu_b, wb_addr and wb_data = 0.
- Latency: an instruction accepted at edge N is in EX after edge N+1 and raises res_valid after edge N+2, provided there is no back-pressure and no stall.
- Throughput: one instruction per cycle with forwarding.
- Back-pressure:
  - res_valid, wb_addr and wb_data are held until res_ready.
  - While res_ready is low with v_wb set, all stages freeze and in_ready = 0.
- Without forwarding, the ID instruction stalls while any valid EX or WB rd equals a nonzero rs. A back-to-back dependency therefore costs 2 cycles.
- Simultaneous result handshake and new accept: legal in the same cycle, and the pipeline shifts.
- Reset mid-operation: all in-flight instructions are discarded immediately and no further wb_en is issued.

## Configuration
- ALU_PIPE_FORWARD_EN defined: EX→ID and WB→ID forwarding is active and there are never hazard stalls.
- ALU_PIPE_FORWARD_EN undefined: the forward muxes are removed and operands always come from the register file. The RAW scoreboard stall described above applies.

## Structure
- Package alu_pipe_pkg holds:
  - the ALU op code constants;
  - the OP and OP-IMM opcode constants;
  - the funct7 constants;
  - a decoded-instruction struct (op, rs1, rs2, rd, imm, use_imm, legal).
- Sub-module alu_pipe_decode: combinational decode of in_instr into that struct.

## Test plan
- Register file preset x1=10, x2=20, x3=30. Issue add x4,x1,x2 with res_ready=1 → res_valid 3 cycles after accept, wb_addr=4, wb_data=30, wb_en=1.
- Back-to-back add x4,x1,x2 then sub x5,x4,x3:
  - With the macro: wb_data=0 for x5, one cycle after x4.
  - Without the macro: x5 result 3 cycles after x4 and in_ready low for 2 cycles.
- addi x6,x1,-3 then srai x7,x6,1 → wb_data 7, then 3. Then slti x8,x1,11 → 1.
- Hold res_ready=0 for 4 cycles with 3 instructions in flight → res_valid and wb_data stable, in_ready=0, no wb_en. On release, results retire in order, one per cycle.
- Issue opcode 0000011 (load) and the R-type word with funct7=0100000, funct3=111 → illegal pulses twice, illegal_cnt=2, no res_valid.
- Assert reset with 3 instructions in flight → all outputs at reset values and no wb_en afterwards. Then add x9,x0,x3 → wb_data=30.
